clock_disp_scan: RTL

- Display-side consumer of the BCD time bus (Hour/Minute/Second, 8-bit packed BCD each) produced by the clock counters.
- Drives a 6-digit multiplexed 7-segment display: one digit active at a time, with a fixed scan rate and a one-cycle anti-ghost blank between digits.
- Latches a time snapshot at each frame start, so a frame never mixes values from two different seconds.
- The Dp output blinks as a colon substitute, following Second[0].

---
 rtl/clock_disp_scan_pkg.sv | 42 ++++
 rtl/clock_disp_scan_if.sv | 33 +++
 rtl/clock_disp_scan_seg7.sv | 27 ++
 rtl/clock_disp_scan.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/clock_disp_scan_pkg.sv
// Shared constants for the clock display scanner: segment patterns,
// digit index map and the scan phase type.
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-high segment patterns, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Digit index map, matching the nibble order of {Hour, Minute, Second}
    localparam logic [2:0] DIG_SU = 3'd0;
    localparam logic [2:0] DIG_ST = 3'd1;
    localparam logic [2:0] DIG_MU = 3'd2;
    localparam logic [2:0] DIG_MT = 3'd3;
    localparam logic [2:0] DIG_HU = 3'd4;
    localparam logic [2:0] DIG_HT = 3'd5;

    typedef enum logic {
        PH_HOLD = 1'b0,
        PH_SHOW = 1'b1
    } scan_phase_t;

    function automatic logic [2:0] next_digit(input logic [2:0] idx);
        return (idx == DIG_HT) ? DIG_SU : idx + 3'd1;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] dig_onehot(input logic [2:0] idx);
        return 6'b000001 << idx;
    endfunction

endpackage

// File: rtl/clock_disp_scan_if.sv
// Time bus in / display bus out for the clock display scanner.
// master: the clock core / board side; slave: the scanner.
interface clock_disp_scan_if;

    logic       En;
    logic [7:0] Hour;
    logic [7:0] Minute;
    logic [7:0] Second;
    logic [6:0] Seg;
    logic       Dp;
    logic [5:0] DigSel;

    modport master (
        output En,
        output Hour,
        output Minute,
        output Second,
        input  Seg,
        input  Dp,
        input  DigSel
    );

    modport slave (
        input  En,
        input  Hour,
        input  Minute,
        input  Second,
        output Seg,
        output Dp,
        output DigSel
    );

endinterface

// File: rtl/clock_disp_scan_seg7.sv
// BCD nibble to active-high 7-segment pattern; non-decimal codes show a dash.
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // pure lookup, every code covered
    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_disp_scan.sv
// Six-digit multiplexed 7-segment scanner for the BCD time bus.
// Each digit slot is CLK_DIV cycles: one blank cycle after the slot tick,
// then the digit for CLK_DIV-1 cycles. A snapshot of {Hour, Minute, Second}
// is taken whenever the scan wraps to digit 0, so a frame is self-consistent.
// Optional build macro: SEG_LZB_EN blanks the hour-tens digit when it is zero.
//
// phase   | meaning
// --------+-----------------------------------------------------------
// PH_HOLD | outputs hold (showing a digit, or blank after reset / En=0)
// PH_SHOW | blank cycle after a tick; next enabled edge shows the digit
module clock_disp_scan
    import clock_disp_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic              CP,
    input  logic              nCR,
    clock_disp_scan_if.slave  bus
);

    localparam int unsigned PRESC_W = $clog2(CLK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    // Output-register encodings of "everything off" for the chosen polarity
    localparam logic [6:0]            SEG_OFF_OUT = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF_OUT  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF_OUT = DIG_ACTIVE_LOW ? 6'h3F : 6'h00;

    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [2:0]            idx_q, idx_d;
    logic [23:0]           snap_q, snap_d;
    scan_phase_t           phase_q, phase_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;

    logic                  tick;
    logic [3:0]            nibble;
    logic [6:0]            seg_raw;
    logic                  lzb_blank;
    logic [6:0]            show_seg;
    logic                  show_dp;
    logic [2:0]            idx_next;

    assign tick     = bus.En && (presc_q == PRESC_LAST);
    assign idx_next = next_digit(idx_q);

    // select the snapshot nibble belonging to the current digit
    always_comb begin
        nibble = snap_q[3:0];
        case (idx_q)
            DIG_SU:  nibble = snap_q[3:0];
            DIG_ST:  nibble = snap_q[7:4];
            DIG_MU:  nibble = snap_q[11:8];
            DIG_MT:  nibble = snap_q[15:12];
            DIG_HU:  nibble = snap_q[19:16];
            DIG_HT:  nibble = snap_q[23:20];
            default: nibble = snap_q[3:0];
        endcase
    end

    bcd_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (seg_raw)
    );

`ifdef SEG_LZB_EN
    assign lzb_blank = (idx_q == DIG_HT) && (snap_q[23:20] == 4'h0);
`else
    assign lzb_blank = 1'b0;
`endif

    // Dp acts as the colon: lit beside the minute and hour units on even seconds
    assign show_seg = lzb_blank ? SEG_OFF : seg_raw;
    assign show_dp  = ((idx_q == DIG_MU) || (idx_q == DIG_HU)) && !snap_q[0] && !lzb_blank;

    // next-state: prescaler, digit index, snapshot, phase and display outputs
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        phase_d = phase_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        dig_d   = dig_q;

        if (!bus.En) begin
            // frozen scan; a pending show is dropped so resume waits for a tick
            phase_d = PH_HOLD;
            seg_d   = SEG_OFF_OUT;
            dp_d    = DP_OFF_OUT;
            dig_d   = DIG_OFF_OUT;
        end else if (tick) begin
            presc_d = '0;
            idx_d   = idx_next;
            if (idx_next == DIG_SU) begin
                snap_d = {bus.Hour, bus.Minute, bus.Second};
            end
            phase_d = PH_SHOW;
            seg_d   = SEG_OFF_OUT;
            dp_d    = DP_OFF_OUT;
            dig_d   = DIG_OFF_OUT;
        end else begin
            presc_d = presc_q + 1'b1;
            if (phase_q == PH_SHOW) begin
                phase_d = PH_HOLD;
                seg_d   = show_seg ^ {7{SEG_ACTIVE_LOW}};
                dp_d    = show_dp ^ SEG_ACTIVE_LOW;
                dig_d   = dig_onehot(idx_q) ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
            end
        end
    end

    // state and output registers, cleared asynchronously by nCR
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            presc_q <= '0;
            idx_q   <= DIG_SU;
            snap_q  <= 24'h000000;
            phase_q <= PH_HOLD;
            seg_q   <= SEG_OFF_OUT;
            dp_q    <= DP_OFF_OUT;
            dig_q   <= DIG_OFF_OUT;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            dig_q   <= dig_d;
        end
    end

    assign bus.Seg    = seg_q;
    assign bus.Dp     = dp_q;
    assign bus.DigSel = dig_q;

endmodule
